instr_prefetch_queue: RTL
=========================

# instr_prefetch_queue

Instruction fetch front end that sits directly upstream of the pipelined CPU's Fetch stage and replaces its combinational instruction-memory read. It fetches 16-bit instructions as two sequential bytes from a byte-wide instruction memory over a req/ack handshake. It buffers complete instructions, tagged with their PC, in a small FIFO and presents them to the CPU with a valid/ready handshake. It flushes and refetches when the CPU redirects on a taken branch (PCSrcE).

## Interface
Parameters:
- DEPTH, 4: instruction queue entries (power of two, ≥2).
- RESET_PC, 8'h00: first instruction address fetched after reset.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- mem_req  out  1  byte request to instruction memory.
- mem_addr  out  9  byte address: {fetch_pc, 1'b0} for high byte, {fetch_pc, 1'b1} for low byte.
- mem_ack  in  1  memory accepts request; mem_rdata valid this cycle.
- mem_rdata  in  8  returned byte.
- instr_out  out  16  head instruction, {high byte, low byte}.
- instr_pc  out  8  PC of head instruction.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  CPU pops head when instr_valid && instr_ready.
- redirect  in  1  taken-branch flush (driven from PCSrcE).
- redirect_pc  in  8  new fetch PC.

## Operation
- FSM states: IDLE, HI, LO, DROP. mem_req = (state != IDLE). mem_addr is held stable while mem_req is high and no ack has arrived.
- IDLE: go to HI when count < DEPTH.
- HI: on mem_ack, latch the byte as hi_byte and go to LO.
- LO: on mem_ack, push {hi_byte, mem_rdata} with tag fetch_pc, then increment fetch_pc (8-bit, 255 wraps to 0).
  - Next state is HI if count_next < DEPTH, else IDLE.
  - count_next = count + 1 − pop.
- Pop, push, or both in the same cycle: count is updated accordingly. The issue rule (HI entered only when count < DEPTH) guarantees no overflow. A pop when empty is ignored.
- redirect has priority over push and pop in the same cycle:
  - Queue is cleared and count is 0 next cycle; a word completing this cycle is discarded.
  - fetch_pc is set to redirect_pc.
- Redirect in IDLE, or in HI/LO with mem_ack in the same cycle: next state is HI.
- Redirect in HI/LO without mem_ack: next state is DROP. DROP keeps mem_req and the old mem_addr until mem_ack, discards the byte, then goes to HI.
- Redirect while in DROP: fetch_pc is updated and the state stays DROP.
- Reset (any cycle, including mid-request):
  - state = IDLE, mem_req = 0, count = 0, fetch_pc = RESET_PC.
  - instr_valid = 0, instr_out = 0, instr_pc = 0, hi_byte = 0.
  - A pending memory ack is ignored.

## Timing
- Zero-wait memory (mem_ack same cycle as mem_req) with reset released before edge 0: cycle 0 IDLE, cycle 1 HI acked, cycle 2 LO acked, instr_valid = 1 in cycle 3.
- Sustained throughput: 1 instruction per 2 cycles with zero-wait memory; 1 per (2 + total wait cycles) otherwise.
- instr_out and instr_pc are registered FIFO head values, stable while instr_valid && !instr_ready.
- Redirect to first new instruction valid: 3 cycles (zero-wait, no outstanding request); +1 + wait cycles when a DROP is needed.

## Structure
- Package fetch_pkg holds:
  - enum fetch_state_t {IDLE, HI, LO, DROP};
  - localparams PC_W = 8, INSTR_W = 16, BYTE_W = 8;
  - the default RESET_PC.
- One sub-module, fetch_fifo: synchronous FIFO of DEPTH × (PC_W + INSTR_W) entries.
  - Ports: push, pop, clear, count, head.
  - Same clock and active-low synchronous reset.
- Top level contains the FSM, fetch_pc, hi_byte and redirect logic.

## Test plan
- Reset, zero-wait ROM with byte[i] = i, instr_ready = 1: instr_valid first in cycle 3 with instr_out = 16'h0001, instr_pc = 0; then 16'h0203 at pc 1 two cycles later.
- instr_ready = 0 with DEPTH = 4: exactly 4 instructions buffered, then mem_req = 0 (IDLE). Popping one restarts fetching of pc 4 in the next cycle.
- Redirect to 8'h40 while in HI with mem_ack held low for 3 cycles:
  - mem_addr stays at the old address until ack;
  - the byte is dropped;
  - the next mem_addr is 9'h080;
  - queue is empty the cycle after redirect.
- Redirect coincident with an LO ack and a pop: the completed word is not enqueued, count = 0, and fetch restarts at redirect_pc.
- fetch_pc = 8'hFF: the instruction at pc 255 is fetched via mem_addr 9'h1FE/9'h1FF, then fetch_pc wraps to 0 (mem_addr 9'h000).
- Reset asserted mid-LO with mem_ack: no push; all outputs take their reset values next cycle; fetching resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction prefetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int BYTE_W  = 8;
   localparam int ADDR_W  = PC_W + 1;   // byte address = {pc, byte select}

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 8'h00;

   // IDLE: queue full, no request. HI/LO: fetching the high/low byte of fetch_pc.
   // DROP: finishing a request that a redirect made stale; its byte is discarded.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   // One queued instruction and the PC it was fetched from.
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions tagged with their PC.
// Latency: a push is visible at head the cycle after it is written into an empty queue.
// Backpressure: push is dropped when full without a pop; pop on empty is ignored; clear wins.
//
// Ports: clk, reset (sync, active-low), push/push_entry (write), pop (advance head),
//        clear (empty the queue), count (occupancy), head (oldest entry, zero when empty).
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W:0]   count_q;

   logic do_pop;
   logic do_push;

   assign do_pop  = pop && (count_q != '0) && !clear;
   // A simultaneous pop frees the slot the push needs, so full-with-pop is allowed.
   assign do_push = push && !clear && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Storage needs no reset: head is forced to zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (reset && do_push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign count = count_q;
   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch: fetches 16-bit instructions as two bytes and queues them for the CPU.
// Latency: 3 cycles from an idle start (or redirect) to instr_valid with zero-wait memory.
// Backpressure: stops issuing memory requests once the queue holds DEPTH instructions.
//
// Ports: clk, reset (sync, active-low)
//        memory side : mem_req, mem_addr, mem_ack, mem_rdata
//        CPU side    : instr_out, instr_pc, instr_valid, instr_ready
//        branch      : redirect, redirect_pc (flush queue, refetch from redirect_pc)
module instr_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [BYTE_W-1:0]  mem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t        state_q,     state_d;
   logic [PC_W-1:0]     fetch_pc_q,  fetch_pc_d;
   logic [BYTE_W-1:0]   hi_byte_q,   hi_byte_d;
   logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;

   logic                push_fire;
   logic                pop_fire;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_after_pop;
   logic [ADDR_W-1:0]   fetch_addr;
   fetch_entry_t        push_entry;
   fetch_entry_t        head;

   // The queue is cleared by a redirect, so a pop in that cycle is meaningless.
   assign pop_fire        = instr_valid && instr_ready && !redirect;
   assign count_after_pop = count - CNT_W'(pop_fire);

   assign fetch_addr = {fetch_pc_q, (state_q == LO)};
   assign mem_req    = (state_q != IDLE);
   // DROP must keep presenting the stale address even though fetch_pc already moved on.
   assign mem_addr   = (state_q == DROP) ? drop_addr_q : fetch_addr;

   assign push_entry.pc    = fetch_pc_q;
   assign push_entry.instr = {hi_byte_q, mem_rdata};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      hi_byte_d   = hi_byte_q;
      drop_addr_d = drop_addr_q;
      push_fire   = 1'b0;

      case (state_q)
         IDLE: begin
            // IDLE never pushes, so only a pop this cycle can open a slot.
            if (count_after_pop < CNT_W'(DEPTH)) begin
               state_d = HI;
            end
         end
         HI: begin
            if (mem_ack) begin
               hi_byte_d = mem_rdata;
               state_d   = LO;
            end
         end
         LO: begin
            if (mem_ack) begin
               push_fire  = 1'b1;
               fetch_pc_d = fetch_pc_q + 1'b1;
               // count_next = count + 1 - pop must stay below DEPTH to keep fetching.
               state_d    = (count_after_pop < CNT_W'(DEPTH - 1)) ? HI : IDLE;
            end
         end
         DROP: begin
            if (mem_ack) begin
               state_d = HI;
            end
         end
         default: state_d = IDLE;
      endcase

      // Redirect overrides whatever the fetch sequence decided above.
      if (redirect) begin
         push_fire  = 1'b0;
         fetch_pc_d = redirect_pc;
         case (state_q)
            HI, LO: begin
               if (mem_ack) begin
                  state_d = HI;
               end else begin
                  state_d     = DROP;
                  drop_addr_d = fetch_addr;
               end
            end
            // An ack arriving with the redirect still retires the stale request.
            DROP:    state_d = mem_ack ? HI : DROP;
            default: state_d = HI;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         hi_byte_q   <= '0;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hi_byte_q   <= hi_byte_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_fire),
      .push_entry (push_entry),
      .pop        (pop_fire),
      .clear      (redirect),
      .count      (count),
      .head       (head)
   );

   assign instr_valid = (count != '0);
   assign instr_out   = head.instr;
   assign instr_pc    = head.pc;

endmodule
